manchester_word_codec: RTL and testbench

- Parametrised, word-framed Manchester transmitter and receiver sharing one clock.
- TX serialises DATA_W-bit words behind a valid/ready handshake; RX oversamples the line, detects frames, decodes words and flags code violations.
- Polarity (IEEE 802.3 or G.E. Thomas) is selectable at elaboration.
- Sits between the parallel datapath and the serial pin; tx_out may loop directly back to rx_in.

---
 rtl/manchester_word_codec.sv | 248 ++++++++++++++++++++++++
 tb/tb_manchester_word_codec.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/manchester_word_codec.sv
// Purpose: word-framed Manchester transmitter and oversampling receiver on one clock.
// Latency: TX busy (1+DATA_W)*OVS + OVS cycles per word; RX flags a word 1 cycle after the last mid-bit sample.
// Backpressure: tx_ready low while a frame or its guard gap is in flight; RX has no backpressure.
//
// Ports:
//   clk, rst            : single clock, synchronous active-high reset
//   tx_valid/tx_ready   : word handshake, tx_data captured on acceptance (MSB sent first)
//   tx_out              : registered Manchester line, idles low
//   rx_in               : asynchronous Manchester line in
//   rx_valid, rx_data   : one-cycle pulse with the decoded word; rx_data holds the last good word
//   rx_err              : one-cycle pulse when a frame is abandoned
//   rx_busy             : receiver is inside a frame or waiting for the line to settle low
//
// Build option: define MANCH_PARITY_EN to append an even-parity symbol to every frame.
module manchester_word_codec #(
  parameter int DATA_W   = 8,
  parameter int OVS      = 8,
  parameter bit IEEE_POL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_out,
  input  logic              rx_in,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_err,
  output logic              rx_busy
);

`ifdef MANCH_PARITY_EN
  localparam int NBITS = DATA_W + 2;
`else
  localparam int NBITS = DATA_W + 1;
`endif
  localparam int PW = $clog2(OVS);
  localparam int BW = $clog2(NBITS + 1);

  localparam logic [PW-1:0] PH_ONE   = PW'(1);
  localparam logic [PW-1:0] PH_LAST  = PW'(OVS - 1);
  localparam logic [PW-1:0] PH_HALF  = PW'(OVS / 2);
  localparam logic [PW-1:0] PH_A     = PW'(OVS / 4);
  localparam logic [PW-1:0] PH_B     = PW'(3 * OVS / 4);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

  // ------------------------------------------------------------------
  // Transmitter
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GUARD} tx_state_t;

  tx_state_t         tx_state;
  logic [PW-1:0]     tx_phase, tx_phase_nx;
  logic [BW-1:0]     tx_bit, tx_bit_nx;
  logic [DATA_W-1:0] tx_shift, tx_shift_nx;
  logic              tx_wrap;
  logic              tx_d;
  logic              tx_sym;
  logic              tx_lvl_nx;
`ifdef MANCH_PARITY_EN
  logic              tx_par;
`endif

  // tx_out is registered, so the level is computed for the phase/bit the
  // counters will hold next cycle.
  always_comb begin
    tx_wrap     = (tx_phase == PH_LAST);
    tx_phase_nx = tx_wrap ? '0 : tx_phase + PH_ONE;
    tx_bit_nx   = tx_wrap ? tx_bit + BIT_ONE : tx_bit;
    // The word is not shifted when leaving the start symbol: its MSB is
    // the first data bit.
    tx_shift_nx = (tx_wrap && tx_bit != '0) ? tx_shift << 1 : tx_shift;
    tx_d        = 1'b0;
    tx_sym      = 1'b1;               // start symbol: high first half
    if (tx_bit_nx != '0) begin
`ifdef MANCH_PARITY_EN
      tx_d = (tx_bit_nx == BIT_LAST) ? tx_par : tx_shift_nx[DATA_W-1];
`else
      tx_d = tx_shift_nx[DATA_W-1];
`endif
      // tx_sym is the first-half level of the data symbol
      tx_sym = IEEE_POL ? ~tx_d : tx_d;
    end
    tx_lvl_nx = (tx_phase_nx < PH_HALF) ? tx_sym : ~tx_sym;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_ready <= 1'b0;
      tx_out   <= 1'b0;
      tx_phase <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
`ifdef MANCH_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_out <= 1'b0;
          if (tx_valid && tx_ready) begin
            tx_state <= TX_SEND;
            tx_ready <= 1'b0;
            tx_shift <= tx_data;
            tx_phase <= '0;
            tx_bit   <= '0;
            tx_out   <= 1'b1;
`ifdef MANCH_PARITY_EN
            tx_par   <= ^tx_data;
`endif
          end else begin
            tx_ready <= 1'b1;
          end
        end
        TX_SEND: begin
          if (tx_wrap && tx_bit == BIT_LAST) begin
            tx_state <= TX_GUARD;
            tx_phase <= '0;
            tx_out   <= 1'b0;
          end else begin
            tx_phase <= tx_phase_nx;
            tx_bit   <= tx_bit_nx;
            tx_shift <= tx_shift_nx;
            tx_out   <= tx_lvl_nx;
          end
        end
        TX_GUARD: begin
          tx_out <= 1'b0;
          if (tx_wrap) begin
            tx_state <= TX_IDLE;
            tx_ready <= 1'b1;
          end else begin
            tx_phase <= tx_phase_nx;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Receiver
  // ------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_FRAME, RX_WAIT} rx_state_t;

  rx_state_t         rx_state;
  logic              rx_meta, rx_s, rx_s_d;
  logic [PW-1:0]     rx_phase;
  logic [BW-1:0]     rx_bit;
  logic [PW-1:0]     rx_low_cnt;
  logic              rx_a;
  logic [DATA_W-1:0] rx_shift, rx_shift_nx;
  logic              rx_dbit;
  logic              rx_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b0;
      rx_s    <= 1'b0;
      rx_s_d  <= 1'b0;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  // Evaluated in the cycle of sample b (phase 3*OVS/4); rx_s is sample b.
  always_comb begin
    rx_dbit     = IEEE_POL ? rx_s : rx_a;
    rx_shift_nx = DATA_W'({rx_shift, rx_dbit});
    // Equal halves are never legal; the start symbol must be high-then-low.
    rx_bad      = (rx_a == rx_s) || (rx_bit == '0 && !rx_a);
`ifdef MANCH_PARITY_EN
    if (rx_bit == BIT_LAST && (^{rx_shift, rx_dbit}))
      rx_bad = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state   <= RX_IDLE;
      rx_valid   <= 1'b0;
      rx_err     <= 1'b0;
      rx_busy    <= 1'b0;
      rx_data    <= '0;
      rx_phase   <= '0;
      rx_bit     <= '0;
      rx_low_cnt <= '0;
      rx_a       <= 1'b0;
      rx_shift   <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_s && !rx_s_d) begin
            rx_state <= RX_FRAME;
            rx_busy  <= 1'b1;
            rx_phase <= '0;
            rx_bit   <= '0;
          end
        end
        RX_FRAME: begin
          rx_phase <= (rx_phase == PH_LAST) ? '0 : rx_phase + PH_ONE;
          if (rx_phase == PH_LAST)
            rx_bit <= rx_bit + BIT_ONE;
          if (rx_phase == PH_A)
            rx_a <= rx_s;
          if (rx_phase == PH_B) begin
            if (rx_bad) begin
              rx_err     <= 1'b1;
              rx_state   <= RX_WAIT;
              rx_low_cnt <= '0;
            end else if (rx_bit == BIT_LAST) begin
              rx_valid <= 1'b1;
              rx_busy  <= 1'b0;
              rx_state <= RX_IDLE;
`ifdef MANCH_PARITY_EN
              rx_data  <= rx_shift;    // last symbol was parity, not data
`else
              rx_data  <= rx_shift_nx;
`endif
            end else if (rx_bit != '0) begin
              rx_shift <= rx_shift_nx;
            end
          end
        end
        RX_WAIT: begin
          // Re-arm only after a full bit period of quiet line.
          if (rx_s) begin
            rx_low_cnt <= '0;
          end else if (rx_low_cnt == PH_LAST) begin
            rx_state <= RX_IDLE;
            rx_busy  <= 1'b0;
          end else begin
            rx_low_cnt <= rx_low_cnt + PH_ONE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_manchester_word_codec.sv
// Purpose: self-checking bench for manchester_word_codec (IEEE and Thomas instances).
// Latency: checks frame timing, guard gap and loopback latency against a line-level model.
// Backpressure: exercises held tx_valid against tx_ready and RX code/parity violations.
module tb_manchester_word_codec;

  localparam int DW  = 8;
  localparam int OVS = 8;
`ifdef MANCH_PARITY_EN
  localparam int NB = DW + 2;
`else
  localparam int NB = DW + 1;
`endif
  localparam int BUSY = NB * OVS + OVS;
  localparam int LAT  = 3 + (NB - 1) * OVS + 3 * OVS / 4 + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_valid, tx_ready, tx_out, rx_in, rx_valid, rx_err, rx_busy;
  logic [DW-1:0] tx_data, rx_data;
  logic          tx_valid_th, tx_ready_th, tx_out_th, rx_in_th, rx_valid_th, rx_err_th, rx_busy_th;
  logic [DW-1:0] tx_data_th, rx_data_th;
  logic          loop_en, rx_drv;

  assign rx_in    = loop_en ? tx_out : rx_drv;
  assign rx_in_th = tx_out_th;

  always #5 clk = ~clk;

  manchester_word_codec #(.DATA_W(DW), .OVS(OVS), .IEEE_POL(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_out(tx_out),
    .rx_in(rx_in), .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err), .rx_busy(rx_busy)
  );

  manchester_word_codec #(.DATA_W(DW), .OVS(OVS), .IEEE_POL(1'b0)) u_dut_th (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid_th), .tx_ready(tx_ready_th), .tx_data(tx_data_th), .tx_out(tx_out_th),
    .rx_in(rx_in_th), .rx_valid(rx_valid_th), .rx_data(rx_data_th), .rx_err(rx_err_th),
    .rx_busy(rx_busy_th)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle stamps and pulse monitors (sampled on the falling edge).
  int            cyc = 0;
  int            n_vld = 0, n_err = 0, vld_cyc = 0;
  int            n_vld_th = 0, n_err_th = 0, vld_cyc_th = 0;
  logic [DW-1:0] vld_dat = '0, vld_dat_th = '0;
  logic [DW-1:0] last_rx = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      n_vld++;
      vld_cyc = cyc;
      vld_dat = rx_data;
    end
    if (rx_err) n_err++;
    if (rx_valid_th) begin
      n_vld_th++;
      vld_cyc_th = cyc;
      vld_dat_th = rx_data_th;
    end
    if (rx_err_th) n_err_th++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line level t cycles after the first high of a frame carrying w.
  function automatic logic exp_line(input logic [DW-1:0] w, input bit ieee, input int t);
    int   k;
    logic d, first;
    if (t < 0 || t >= NB * OVS) return 1'b0;
    k = t / OVS;
    if (k == 0) begin
      first = 1'b1;
    end else begin
      if (k <= DW) d = w[DW-k];
      else         d = ^w;
      first = ieee ? !d : d;
    end
    return ((t % OVS) < OVS / 2) ? first : !first;
  endfunction

  // Loopback word on the IEEE instance.
  task automatic send_word(input logic [DW-1:0] w, input logic [DW-1:0] nxt,
                           input bit hold, input bit ready_now);
    int wait_n, mis, rdy_mis, guard_low, v0, e0, start;
    tx_valid = 1'b1;
    tx_data  = w;
    wait_n   = 0;
    while (!tx_ready && wait_n < 200) begin
      tick();
      wait_n++;
    end
    if (wait_n >= 200) check("tx_ready_timeout", tx_ready, 1);
    if (ready_now) check("b2b_ready_wait", wait_n, 0);
    v0 = n_vld;
    e0 = n_err;
    tick();                       // acceptance edge
    start     = cyc;
    tx_valid  = hold;
    tx_data   = nxt;
    mis       = 0;
    rdy_mis   = 0;
    guard_low = 0;
    for (int t = 0; t <= BUSY; t++) begin
      if (t > 0) tick();
      if (t < BUSY) begin
        if (tx_out !== exp_line(w, 1'b1, t)) mis++;
        if (tx_ready !== 1'b0) rdy_mis++;
        if (t >= NB * OVS && tx_out === 1'b0) guard_low++;
      end
    end
    check("tx_line", mis, 0);
    check("tx_ready_busy", rdy_mis, 0);
    check("tx_ready_back", tx_ready, 1);
    check("guard_low", guard_low, OVS);
    check("rx_valid_cnt", n_vld - v0, 1);
    check("rx_err_cnt", n_err - e0, 0);
    check("rx_data_pulse", vld_dat, w);
    check("rx_data_port", rx_data, w);
    check("rx_latency", vld_cyc - start, LAT);
    check("rx_busy_after", rx_busy, 0);
    last_rx = w;
  endtask

  // Loopback word on the Thomas-polarity instance.
  task automatic send_word_th(input logic [DW-1:0] w, input bit chk_b7);
    int        wait_n, mis, v0, e0, start;
    logic [7:0] b7;
    tx_valid_th = 1'b1;
    tx_data_th  = w;
    wait_n      = 0;
    b7          = '0;
    while (!tx_ready_th && wait_n < 200) begin
      tick();
      wait_n++;
    end
    if (wait_n >= 200) check("th_ready_timeout", tx_ready_th, 1);
    v0 = n_vld_th;
    e0 = n_err_th;
    tick();
    start       = cyc;
    tx_valid_th = 1'b0;
    tx_data_th  = ~w;
    mis         = 0;
    for (int t = 0; t <= BUSY; t++) begin
      if (t > 0) tick();
      if (t < BUSY && tx_out_th !== exp_line(w, 1'b0, t)) mis++;
      if (t >= OVS && t < 2 * OVS) b7 = {b7[6:0], tx_out_th};
    end
    check("th_tx_line", mis, 0);
    if (chk_b7) check("th_bit7_wave", b7, 8'hF0);
    check("th_rx_valid_cnt", n_vld_th - v0, 1);
    check("th_rx_err_cnt", n_err_th - e0, 0);
    check("th_rx_data", vld_dat_th, w);
    check("th_rx_latency", vld_cyc_th - start, LAT);
  endtask

  // Bench-driven frame into the IEEE receiver (loop_en must be 0).
  task automatic drive_frame(input logic [DW-1:0] w, input bit flip_par, input bit exp_ok);
    int   v0, e0, start;
    logic lv;
    v0    = n_vld;
    e0    = n_err;
    start = cyc;
    for (int t = 0; t < NB * OVS; t++) begin
      lv = exp_line(w, 1'b1, t);
      if (flip_par && t >= (NB - 1) * OVS) lv = !lv;
      rx_drv = lv;
      tick();
    end
    rx_drv = 1'b0;
    repeat (2 * OVS) tick();
    if (exp_ok) begin
      check("drv_valid_cnt", n_vld - v0, 1);
      check("drv_err_cnt", n_err - e0, 0);
      check("drv_data", vld_dat, w);
      check("drv_latency", vld_cyc - start, LAT);
      last_rx = w;
    end else begin
      check("drv_bad_valid_cnt", n_vld - v0, 0);
      check("drv_bad_err_cnt", n_err - e0, 1);
    end
    check("drv_data_port", rx_data, last_rx);
    check("drv_busy_after", rx_busy, 0);
  endtask

  initial begin
    int            v0, e0, low_start, drop, t;
    logic [DW-1:0] w;

    rst         = 1'b1;
    tx_valid    = 1'b0;
    tx_data     = '0;
    tx_valid_th = 1'b0;
    tx_data_th  = '0;
    loop_en     = 1'b1;
    rx_drv      = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_ctrl", {tx_out, tx_ready, rx_valid, rx_err, rx_busy}, 5'b0);
    check("rst_rx_data", rx_data, 0);
    check("rst_ctrl_th", {tx_out_th, tx_ready_th, rx_valid_th, rx_err_th, rx_busy_th}, 5'b0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", tx_ready, 1);

    // Single loopback word, then back-to-back with tx_valid held
    send_word(8'hA5, 8'h3C, 1'b0, 1'b0);
    send_word(8'h00, 8'hFF, 1'b1, 1'b0);
    send_word(8'hFF, 8'h3C, 1'b1, 1'b1);
    send_word(8'h3C, 8'h96, 1'b0, 1'b1);

    // Random loopback words with random idle gaps
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 5)) tick();
      w = DW'($urandom);
      send_word(w, DW'($urandom), 1'b0, 1'b0);
    end

    // Thomas polarity
    send_word_th(8'h81, 1'b1);
    for (int i = 0; i < 3; i++) send_word_th(DW'($urandom), 1'b0);

    // Code violation: start symbol, then a full bit period stuck high
    loop_en = 1'b0;
    rx_drv  = 1'b0;
    repeat (4) tick();
    v0 = n_vld;
    e0 = n_err;
    for (int k = 0; k < 2 * OVS; k++) begin
      rx_drv = (k < OVS / 2) || (k >= OVS);
      tick();
    end
    rx_drv = 1'b0;
    repeat (4) tick();
    rx_drv = 1'b1;               // glitch while waiting must restart the quiet count
    tick();
    rx_drv    = 1'b0;
    low_start = cyc;
    drop      = -1;
    t         = 0;
    while (drop < 0 && t < 60) begin
      tick();
      t++;
      if (!rx_busy) drop = cyc;
    end
    check("viol_err_cnt", n_err - e0, 1);
    check("viol_valid_cnt", n_vld - v0, 0);
    check("viol_busy_release", drop - low_start, OVS + 2);
    check("viol_data_kept", rx_data, last_rx);
    drive_frame(8'h5A, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive_frame(DW'($urandom), 1'b0, 1'b1);

`ifdef MANCH_PARITY_EN
    // Parity symbol with swapped halves, then the same word intact
    drive_frame(8'h07, 1'b1, 1'b0);
    drive_frame(8'h07, 1'b0, 1'b1);
`endif

    // Reset for one cycle in the middle of bit 4
    loop_en  = 1'b1;
    tx_valid = 1'b1;
    tx_data  = DW'($urandom);
    t        = 0;
    while (!tx_ready && t < 200) begin
      tick();
      t++;
    end
    tick();
    tx_valid = 1'b0;
    repeat (4 * OVS + 3) tick();
    v0  = n_vld;
    e0  = n_err;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_tx_out", tx_out, 0);
    check("midrst_tx_ready", tx_ready, 0);
    check("midrst_rx_busy", rx_busy, 0);
    tick();
    check("midrst_ready_back", tx_ready, 1);
    repeat (BUSY + 20) tick();
    check("midrst_no_valid", n_vld - v0, 0);
    check("midrst_no_err", n_err - e0, 0);
    check("midrst_rx_data", rx_data, 0);
    check("th_err_total", n_err_th, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
